// File: rtl/ifu_fetch.sv
// ifu_fetch -- instruction fetch unit front end.
//
// Issues fetch requests on a req/gnt/rvalid instruction bus, buffers the
// in-order read responses in a 2-entry {addr, data} FIFO and presents the
// FIFO head to the decode stage. A redirect from ctrl flushes the FIFO and
// restarts fetching at the (word-aligned) jump target. Responses belonging
// to requests issued before the redirect are drained and discarded.
//
// Configuration macro:
//   IFU_PREFETCH_EN  defined   -> up to 2 requests outstanding (pipelined)
//                    undefined -> 1 request outstanding at a time
//
// Ports:
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   jump_addr_i/_en_i   redirect target and redirect/flush request
//   hold_flag_i         pipeline stall; the head instruction is not consumed
//   ibus_req_o/addr_o   fetch request and fetch address (the PC register)
//   ibus_gnt_i          request accepted when req and gnt are both high
//   ibus_rvalid_i/rdata response valid and read data, in request order
//   inst_o/inst_addr_o  instruction and its PC for decode
//   inst_valid_o        inst_o holds a fetched instruction
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] jump_addr_i,
    input  logic        jump_en_i,
    input  logic        hold_flag_i,
    output logic        ibus_req_o,
    output logic [31:0] ibus_addr_o,
    input  logic        ibus_gnt_i,
    input  logic        ibus_rvalid_i,
    input  logic [31:0] ibus_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        inst_valid_o
);

`ifdef IFU_PREFETCH_EN
    localparam logic [1:0] MAX_OUT = 2'd2;
`else
    localparam logic [1:0] MAX_OUT = 2'd1;
`endif

    typedef enum logic {
        S_RUN   = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic        r_req;
    logic        w_req_next;
    logic [1:0]  r_out;
    logic [1:0]  w_out_next;
    logic [1:0]  r_cnt;
    logic [1:0]  w_cnt_next;
    logic [2:0]  w_reserved_next;
    logic        r_gptr;
    logic        r_wptr;
    logic        r_rptr;
    logic [31:0] r_fifo_addr [2];
    logic [31:0] r_fifo_data [2];
    logic [31:0] r_last_addr;
    logic        w_grant;
    logic        w_rsp;
    logic        w_push;
    logic        w_pop;
    logic        w_valid;

    always_comb begin
        w_grant = r_req & ibus_gnt_i;
        // A response with nothing outstanding is stale (e.g. from before reset).
        w_rsp   = ibus_rvalid_i & (r_out != 2'd0);
        w_valid = (r_cnt != 2'd0);
        // Responses are only kept in RUN; in DRAIN or on a redirect they are dropped.
        w_push  = w_rsp & (r_state == S_RUN) & ~jump_en_i;
        w_pop   = w_valid & ~hold_flag_i & ~jump_en_i;

        w_out_next = r_out;
        if (w_grant & ~w_rsp) begin
            w_out_next = r_out + 2'd1;
        end else if (~w_grant & w_rsp) begin
            w_out_next = r_out - 2'd1;
        end

        w_cnt_next = r_cnt;
        if (jump_en_i) begin
            w_cnt_next = 2'd0;
        end else if (w_push & ~w_pop) begin
            w_cnt_next = r_cnt + 2'd1;
        end else if (~w_push & w_pop) begin
            w_cnt_next = r_cnt - 2'd1;
        end

        w_pc_next = r_pc;
        if (jump_en_i) begin
            w_pc_next = {jump_addr_i[31:2], 2'b00};
        end else if (w_grant) begin
            w_pc_next = r_pc + 32'd4;
        end

        w_state_next = r_state;
        case (r_state)
            S_RUN: begin
                // A grant in the redirect cycle counts as outstanding too.
                if (jump_en_i && (w_out_next != 2'd0)) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!jump_en_i && (w_out_next == 2'd0)) begin
                    w_state_next = S_RUN;
                end
            end
            default: w_state_next = S_RUN;
        endcase

        // Request is registered and computed from next-cycle occupancy, so it
        // can only rise while waiting for a grant, never fall (except on jump).
        w_reserved_next = {1'b0, w_cnt_next} + {1'b0, w_out_next};
        w_req_next = (w_state_next == S_RUN) & ~jump_en_i &
                     (w_reserved_next < 3'd2) & (w_out_next < MAX_OUT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_RUN;
            r_pc        <= RESET_PC;
            r_req       <= 1'b0;
            r_out       <= 2'd0;
            r_cnt       <= 2'd0;
            r_gptr      <= 1'b0;
            r_wptr      <= 1'b0;
            r_rptr      <= 1'b0;
            r_last_addr <= RESET_PC;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_req   <= w_req_next;
            r_out   <= w_out_next;
            r_cnt   <= w_cnt_next;
            if (jump_en_i) begin
                r_gptr <= 1'b0;
                r_wptr <= 1'b0;
                r_rptr <= 1'b0;
            end else begin
                r_gptr <= r_gptr ^ w_grant;
                r_wptr <= r_wptr ^ w_push;
                r_rptr <= r_rptr ^ w_pop;
            end
            if (w_valid) begin
                r_last_addr <= r_fifo_addr[r_rptr];
            end
        end
    end

    // The address half of an entry is reserved at grant, the data half is
    // filled when the matching response arrives.
    always_ff @(posedge clk) begin
        if (w_grant & ~jump_en_i) begin
            r_fifo_addr[r_gptr] <= r_pc;
        end
        if (w_push) begin
            r_fifo_data[r_wptr] <= ibus_rdata_i;
        end
    end

    assign ibus_req_o   = r_req;
    assign ibus_addr_o  = r_pc;
    assign inst_valid_o = w_valid;
    assign inst_o       = w_valid ? r_fifo_data[r_rptr] : NOP_INST;
    assign inst_addr_o  = w_valid ? r_fifo_addr[r_rptr] : r_last_addr;

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] jump_addr;
    logic        jump_en;
    logic        hold;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic [31:0] inst;
    logic [31:0] inst_addr;
    logic        inst_valid;

    int errors;
    int checks;

    logic [63:0] sb_q [$];
    logic [31:0] pa_q [$];
    int          pc_q [$];

    typedef struct {
        logic        jmp;
        logic [31:0] jaddr;
        logic        hld;
        logic        g;
        logic        rv;
        logic [31:0] rd;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_iaddr;
        logic [31:0] e_inst;
    } vec_t;

    ifu_fetch dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .jump_addr_i   (jump_addr),
        .jump_en_i     (jump_en),
        .hold_flag_i   (hold),
        .ibus_req_o    (req),
        .ibus_addr_o   (addr),
        .ibus_gnt_i    (gnt),
        .ibus_rvalid_i (rvalid),
        .ibus_rdata_i  (rdata),
        .inst_o        (inst),
        .inst_addr_o   (inst_addr),
        .inst_valid_o  (inst_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fdat(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    function automatic vec_t mk(input logic j, input logic [31:0] ja, input logic h,
                                input logic g, input logic rv, input logic [31:0] rd,
                                input logic er, input logic [31:0] ea, input logic ev,
                                input logic [31:0] eia, input logic [31:0] ei);
        vec_t v;
        v.jmp = j; v.jaddr = ja; v.hld = h; v.g = g; v.rv = rv; v.rd = rd;
        v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_iaddr = eia; v.e_inst = ei;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clr_in();
        jump_addr = 32'h0;
        jump_en   = 1'b0;
        hold      = 1'b0;
        gnt       = 1'b0;
        rvalid    = 1'b0;
        rdata     = 32'h0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clr_in();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_req(input string nm);
        int n;
        n = 0;
        while (!req && n < 10) begin
            step();
            n++;
        end
        chk1({nm, " wait req"}, req, 1'b1);
    endtask

    // Redirect while one request is outstanding, then a second redirect in DRAIN.
    task automatic seq_drain_jump();
        do_reset();
        wait_req("dj");
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        jump_en = 1'b1;
        jump_addr = 32'h0000_1000;
        step();
        chk1("dj drain req", req, 1'b0);
        chk("dj first target", addr, 32'h0000_1000);
        jump_addr = 32'h0000_0200;
        step();
        jump_en = 1'b0;
        chk1("dj still drain req", req, 1'b0);
        chk("dj second target", addr, 32'h0000_0200);
        rvalid = 1'b1;
        rdata = 32'hDEAD_BEEF;
        step();
        rvalid = 1'b0;
        chk1("dj stale dropped", inst_valid, 1'b0);
        chk1("dj run req", req, 1'b1);
        chk("dj run addr", addr, 32'h0000_0200);
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        chk("dj after grant", addr, 32'h0000_0204);
        rvalid = 1'b1;
        rdata = fdat(32'h0000_0200);
        step();
        rvalid = 1'b0;
        chk1("dj valid", inst_valid, 1'b1);
        chk("dj inst addr", inst_addr, 32'h0000_0200);
        chk("dj inst", inst, fdat(32'h0000_0200));
    endtask

    // Unaligned jump to the top word, then the PC must wrap to zero.
    task automatic seq_wrap();
        do_reset();
        wait_req("wr");
        jump_en = 1'b1;
        jump_addr = 32'hFFFF_FFFF;
        step();
        jump_en = 1'b0;
        chk1("wr req after jump", req, 1'b0);
        chk("wr aligned pc", addr, 32'hFFFF_FFFC);
        step();
        chk1("wr req", req, 1'b1);
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        chk("wr wrapped pc", addr, 32'h0000_0000);
        rvalid = 1'b1;
        rdata = fdat(32'hFFFF_FFFC);
        step();
        rvalid = 1'b0;
        chk1("wr valid", inst_valid, 1'b1);
        chk("wr inst addr", inst_addr, 32'hFFFF_FFFC);
        chk("wr inst", inst, fdat(32'hFFFF_FFFC));
    endtask

    // Reset with one request in flight; its late response must be ignored.
    task automatic seq_reset_mid();
        do_reset();
        wait_req("rm");
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk1("rm async req", req, 1'b0);
        chk1("rm async valid", inst_valid, 1'b0);
        chk("rm async pc", addr, 32'h0000_0000);
        @(negedge clk);
        rst_n = 1'b1;
        rvalid = 1'b1;
        rdata = 32'hBADB_AD00;
        step();
        chk1("rm stale 1", inst_valid, 1'b0);
        step();
        rvalid = 1'b0;
        chk1("rm stale 2", inst_valid, 1'b0);
        chk1("rm req", req, 1'b1);
        chk("rm addr", addr, 32'h0000_0000);
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        chk1("rm before rsp", inst_valid, 1'b0);
        rvalid = 1'b1;
        rdata = fdat(32'h0);
        step();
        rvalid = 1'b0;
        chk1("rm valid", inst_valid, 1'b1);
        chk("rm inst addr", inst_addr, 32'h0000_0000);
        chk("rm inst", inst, fdat(32'h0));
    endtask

`ifdef IFU_PREFETCH_EN
    // Two outstanding requests dropped by a redirect.
    task automatic seq_pf_jump();
        do_reset();
        wait_req("pf");
        gnt = 1'b1;
        step();
        chk1("pf back-to-back req", req, 1'b1);
        chk("pf second addr", addr, 32'h0000_0004);
        step();
        gnt = 1'b0;
        jump_en = 1'b1;
        jump_addr = 32'h0000_1002;
        step();
        jump_en = 1'b0;
        chk1("pf drain req", req, 1'b0);
        chk("pf target", addr, 32'h0000_1000);
        rvalid = 1'b1;
        rdata = fdat(32'h0);
        step();
        chk1("pf one left req", req, 1'b0);
        chk1("pf drop 1", inst_valid, 1'b0);
        rdata = fdat(32'h4);
        step();
        rvalid = 1'b0;
        chk1("pf drop 2", inst_valid, 1'b0);
        chk1("pf run req", req, 1'b1);
        chk("pf run addr", addr, 32'h0000_1000);
    endtask
`endif

    // Random grant/response/stall traffic checked against a scoreboard of
    // granted addresses, with a forced stall window that fills the buffer.
    task automatic run_stream(input int ncyc);
        logic [31:0] exp_pc;
        logic [31:0] p_addr;
        logic [31:0] p_iaddr;
        logic [63:0] e;
        logic        p_req;
        logic        p_gnt;
        logic        p_valid;
        logic        p_hold;
        logic        forced;
        logic        draining;
        exp_pc = 32'h0;
        sb_q.delete();
        pa_q.delete();
        pc_q.delete();
        p_req = 1'b0; p_gnt = 1'b0; p_valid = 1'b0; p_hold = 1'b0;
        p_addr = 32'h0; p_iaddr = 32'h0;
        do_reset();
        for (int cyc = 0; cyc < ncyc + 60; cyc++) begin
            forced = (cyc >= 100 && cyc < 106);
            draining = (cyc >= ncyc);
            if (p_req && !p_gnt) begin
                chk1("st req held", req, 1'b1);
                chk("st addr held", addr, p_addr);
            end
            if (p_valid && p_hold) begin
                chk1("st hold valid", inst_valid, 1'b1);
                chk("st hold frozen", inst_addr, p_iaddr);
            end
            if (cyc == 105) begin
                chk("st full entries", sb_q.size(), 32'd2);
                chk("st full pending", pa_q.size(), 32'd0);
                chk1("st full req", req, 1'b0);
            end
            if (forced) begin
                gnt = 1'b1;
                hold = 1'b1;
            end else if (draining) begin
                gnt = 1'b0;
                hold = 1'b0;
            end else begin
                gnt = ($urandom_range(0, 3) != 0);
                hold = ($urandom_range(0, 3) == 0);
            end
            rvalid = 1'b0;
            rdata = 32'h0;
            if (pa_q.size() > 0 && pc_q[0] < cyc &&
                (forced || draining || $urandom_range(0, 2) != 0)) begin
                rvalid = 1'b1;
                rdata = fdat(pa_q.pop_front());
                void'(pc_q.pop_front());
            end
            if (req && gnt) begin
                chk("st grant addr", addr, exp_pc);
                sb_q.push_back({exp_pc, fdat(exp_pc)});
                pa_q.push_back(exp_pc);
                pc_q.push_back(cyc);
                exp_pc = exp_pc + 32'd4;
            end
            if (inst_valid && !hold) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL st pop: got instruction at %h expected none", inst_addr);
                end else begin
                    e = sb_q.pop_front();
                    chk("st pop addr", inst_addr, e[63:32]);
                    chk("st pop data", inst, e[31:0]);
                end
            end
            p_req = req; p_gnt = gnt; p_addr = addr;
            p_valid = inst_valid; p_hold = hold; p_iaddr = inst_addr;
            step();
        end
        clr_in();
        chk("st all consumed", sb_q.size(), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[19];
        errors = 0;
        checks = 0;
        clr_in();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk1("reset req", req, 1'b0);
        chk1("reset valid", inst_valid, 1'b0);
        chk("reset pc", addr, 32'h0000_0000);
        chk("reset inst", inst, NOP);
        chk("reset inst addr", inst_addr, 32'h0000_0000);

`ifndef IFU_PREFETCH_EN
        //            jmp  jaddr         hld  g   rv  rdata          req addr          vld iaddr         inst
        tbl[0]  = mk(1'b0, 32'h0,        1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0,       1'b0,32'h0,       NOP);
        tbl[1]  = mk(1'b0, 32'h0,        1'b0,1'b1,1'b0,32'h0,        1'b1,32'h0,       1'b0,32'h0,       NOP);
        tbl[2]  = mk(1'b0, 32'h0,        1'b0,1'b1,1'b1,32'h1111_0000,1'b0,32'h4,       1'b0,32'h0,       NOP);
        tbl[3]  = mk(1'b0, 32'h0,        1'b0,1'b1,1'b0,32'h0,        1'b1,32'h4,       1'b1,32'h0,       32'h1111_0000);
        tbl[4]  = mk(1'b0, 32'h0,        1'b0,1'b0,1'b1,32'h2222_0004,1'b0,32'h8,       1'b0,32'h0,       NOP);
        tbl[5]  = mk(1'b0, 32'h0,        1'b1,1'b1,1'b0,32'h0,        1'b1,32'h8,       1'b1,32'h4,       32'h2222_0004);
        tbl[6]  = mk(1'b0, 32'h0,        1'b1,1'b0,1'b1,32'h3333_0008,1'b0,32'hC,       1'b1,32'h4,       32'h2222_0004);
        tbl[7]  = mk(1'b0, 32'h0,        1'b1,1'b1,1'b0,32'h0,        1'b0,32'hC,       1'b1,32'h4,       32'h2222_0004);
        tbl[8]  = mk(1'b0, 32'h0,        1'b0,1'b0,1'b0,32'h0,        1'b0,32'hC,       1'b1,32'h4,       32'h2222_0004);
        tbl[9]  = mk(1'b0, 32'h0,        1'b0,1'b0,1'b0,32'h0,        1'b1,32'hC,       1'b1,32'h8,       32'h3333_0008);
        tbl[10] = mk(1'b0, 32'h0,        1'b0,1'b0,1'b0,32'h0,        1'b1,32'hC,       1'b0,32'h8,       NOP);
        tbl[11] = mk(1'b1, 32'h0000_1002,1'b0,1'b1,1'b0,32'h0,        1'b1,32'hC,       1'b0,32'h8,       NOP);
        tbl[12] = mk(1'b0, 32'h0,        1'b0,1'b0,1'b1,32'hDEAD_BEEF,1'b0,32'h1000,    1'b0,32'h8,       NOP);
        tbl[13] = mk(1'b0, 32'h0,        1'b0,1'b1,1'b0,32'h0,        1'b1,32'h1000,    1'b0,32'h8,       NOP);
        tbl[14] = mk(1'b0, 32'h0,        1'b0,1'b0,1'b1,32'h4444_1000,1'b0,32'h1004,    1'b0,32'h8,       NOP);
        tbl[15] = mk(1'b1, 32'h0000_0200,1'b1,1'b0,1'b0,32'h0,        1'b1,32'h1004,    1'b1,32'h1000,    32'h4444_1000);
        tbl[16] = mk(1'b0, 32'h0,        1'b0,1'b0,1'b1,32'h0000_0BAD,1'b0,32'h200,     1'b0,32'h1000,    NOP);
        tbl[17] = mk(1'b0, 32'h0,        1'b0,1'b0,1'b0,32'h0,        1'b1,32'h200,     1'b0,32'h1000,    NOP);
        tbl[18] = mk(1'b0, 32'h0,        1'b0,1'b0,1'b0,32'h0,        1'b1,32'h200,     1'b0,32'h1000,    NOP);
        rst_n = 1'b1;
        for (int i = 0; i < 19; i++) begin
            chk1($sformatf("row%0d req", i), req, tbl[i].e_req);
            chk($sformatf("row%0d addr", i), addr, tbl[i].e_addr);
            chk1($sformatf("row%0d valid", i), inst_valid, tbl[i].e_valid);
            chk($sformatf("row%0d inst addr", i), inst_addr, tbl[i].e_iaddr);
            chk($sformatf("row%0d inst", i), inst, tbl[i].e_inst);
            jump_en   = tbl[i].jmp;
            jump_addr = tbl[i].jaddr;
            hold      = tbl[i].hld;
            gnt       = tbl[i].g;
            rvalid    = tbl[i].rv;
            rdata     = tbl[i].rd;
            step();
        end
        clr_in();
`endif

        seq_drain_jump();
        clr_in();
        seq_wrap();
        clr_in();
        seq_reset_mid();
        clr_in();
`ifdef IFU_PREFETCH_EN
        seq_pf_jump();
        clr_in();
`endif
        run_stream(300);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, which is the first fetch address after reset.
REQ-002 SHALL have parameter NOP_INST, default 32'h0000_0013, which is the instruction driven when no instruction is valid.
REQ-003 SHALL have ports:
- clk  input  1  single clock, all state on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- jump_addr_i  input  32  redirect target, from ctrl.
- jump_en_i  input  1  redirect/flush request, from ctrl.
- hold_flag_i  input  1  pipeline stall, from ctrl.
- ibus_req_o  output  1  fetch request.
- ibus_addr_o  output  32  fetch address.
- ibus_gnt_i  input  1  request accepted in the cycle req and gnt are both high.
- ibus_rvalid_i  input  1  read response valid; responses return in order, at least 1 cycle after grant.
- ibus_rdata_i  input  32  read data.
- inst_o  output  32  instruction to the decode stage.
- inst_addr_o  output  32  PC of inst_o.
- inst_valid_o  output  1  inst_o is valid.

Function
REQ-004 SHALL hold fetch PC register pc; ibus_addr_o = pc; on each grant pc SHALL advance by 4, with 32-bit wrap (32'hFFFF_FFFC -> 0).
REQ-005 SHALL hold ibus_req_o and ibus_addr_o stable while ibus_req_o=1 and ibus_gnt_i=0, except when a jump occurs.
REQ-006 SHALL buffer responses in a 2-entry FIFO of {addr, data}; each granted request SHALL reserve one entry; ibus_req_o=1 only when (fifo_count + outstanding) < 2 and outstanding < MAX_OUT.
REQ-007 SHALL drive inst_valid_o = FIFO not empty, inst_o/inst_addr_o = head entry; when empty, inst_o = NOP_INST and inst_addr_o = the last head address.
REQ-008 SHALL pop the head when inst_valid_o=1, hold_flag_i=0 and jump_en_i=0; response write and pop in the same cycle SHALL both take effect.
REQ-009 SHALL implement FSM RUN/DRAIN. In RUN: on jump_en_i, flush the FIFO, set pc <= {jump_addr_i[31:2],2'b00}, deassert ibus_req_o from the next cycle, and enter DRAIN if outstanding (including a grant in the same cycle) > 0, else stay in RUN.
REQ-010 In DRAIN SHALL issue no requests, discard every ibus_rvalid_i, and return to RUN in the cycle after outstanding reaches 0; the first request after a jump SHALL carry the jump target.
REQ-011 A jump during DRAIN SHALL overwrite pc with the newest target and remain in DRAIN.
REQ-012 jump_en_i SHALL take priority over hold_flag_i and over a same-cycle pop.
REQ-013 hold_flag_i without jump SHALL freeze the outputs while fetching continues until the FIFO is reserved full.
REQ-014 SHALL ignore ibus_rvalid_i when outstanding = 0 (no state change).
REQ-015 The outstanding counter SHALL increment on grant and decrement on rvalid; both in the same cycle SHALL leave it unchanged.

Reset
REQ-016 On rst_n=0, asynchronously: pc=RESET_PC, FSM=RUN, FIFO empty, outstanding=0, ibus_req_o=0, inst_valid_o=0, inst_o=NOP_INST, inst_addr_o=RESET_PC.
REQ-017 ibus_req_o SHALL first assert in the first clock edge after rst_n deasserts.
REQ-018 Reset mid-transaction SHALL abandon all in-flight requests; after reset, responses are accepted only for post-reset grants.

Configuration
REQ-019 Macro IFU_PREFETCH_EN: defined -> MAX_OUT=2 (pipelined fetch, back-to-back grants); undefined -> MAX_OUT=1 (next request only after the previous response). All other behaviour SHALL be identical.

Verification
REQ-020 Reset release, gnt=1 always, rvalid 1 cycle after grant, hold=0 -> addresses 0,4,8 issued; inst_valid_o shows addr 0 two cycles after the first grant.
REQ-021 hold_flag_i=1 for 5 cycles during streaming -> inst_o frozen, exactly 2 buffered entries, ibus_req_o=0 while full; release -> in-order 0,4,... with none lost or duplicated.
REQ-022 Jump to 32'h0000_1002 with 2 outstanding (IFU_PREFETCH_EN) -> both responses dropped, FIFO empty, next ibus_addr_o=32'h0000_1000 only after outstanding=0.
REQ-023 Second jump to 32'h200 while in DRAIN -> first fetch after drain is 32'h200.
REQ-024 pc=32'hFFFF_FFFC granted -> next address 32'h0000_0000.
REQ-025 Assert rst_n=0 with 1 outstanding, then release; the stale rvalid arrives -> ignored, inst_valid_o stays 0 until the response for RESET_PC.
